seq_div63: RTL

Sequential restoring divider: 6-bit unsigned dividend by 3-bit unsigned divisor, yielding a 6-bit quotient and a 3-bit remainder. It is the inverse datapath of the team's 3x3 array/Wallace multiplier: a 6-bit product plus a 3-bit factor recovers the other factor. The divider retires one quotient bit per clock behind a start/busy/done handshake. It sits beside the multiplier in the small-arithmetic library.

---
 rtl/seq_div63.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/seq_div63.sv
// -----------------------------------------------------------------------------
// seq_div63 -- sequential restoring divider, 6-bit dividend / 3-bit divisor.
//
// Retires one quotient bit per clock, MSB first, behind a start/busy/done
// handshake. A start accepted in IDLE is followed by six RUN cycles and one
// DONE cycle. The results are then held until the next accepted start or
// until reset.
//
// Ports
//   clk       in   1  rising-edge clock
//   rst       in   1  synchronous reset, active-high
//   start     in   1  request, sampled only in IDLE
//   dividend  in   6  unsigned numerator, captured on the accepting edge
//   divisor   in   3  unsigned denominator, captured on the accepting edge
//   busy      out  1  high while the iterations run
//   done      out  1  one-cycle pulse, results valid in this cycle
//   quot      out  6  quotient, held until the next accepted start
//   rem       out  3  remainder, held until the next accepted start
//   dz        out  1  divide-by-zero flag, valid with done
//
// Build option
//   DIV0_DETECT_EN : when defined, a zero divisor bypasses RUN. The operation
//                    completes one cycle after the accepting edge with
//                    quot=3F, rem=0 and dz=1. When undefined, a zero divisor
//                    runs the normal iterations, and dz is tied low.
// -----------------------------------------------------------------------------
module seq_div63 (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [5:0] dividend,
   input  logic [2:0] divisor,
   output logic       busy,
   output logic       done,
   output logic [5:0] quot,
   output logic [2:0] rem,
   output logic       dz
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] dvd_q,   dvd_d;    // dividend, shifted left so bit 5 is the next bit
   logic [2:0] dvs_q,   dvs_d;
   logic [2:0] prem_q,  prem_d;   // partial remainder
   logic [5:0] qsr_q,   qsr_d;    // quotient shift register
   logic [2:0] cnt_q,   cnt_d;
   logic [5:0] quot_q,  quot_d;
   logic [2:0] rem_q,   rem_d;
`ifdef DIV0_DETECT_EN
   logic       dz_q,    dz_d;
`endif

   // Datapath for one restoring step
   logic       bit_b;
   logic [4:0] diff;
   logic       borrow;
   logic [2:0] prem_nxt;
   logic       q_bit;

   always_comb begin
      bit_b  = dvd_q[5];
      // The extra top bit catches the borrow of the 4-bit trial subtraction.
      diff   = {1'b0, prem_q, bit_b} - {2'b00, dvs_q};
      borrow = diff[4];
      // On a borrow, the restored value {prem,b} is below the divisor. A 3-bit
      // divisor is at most 7, so {prem[1:0],b} loses no information.
      prem_nxt = borrow ? {prem_q[1:0], bit_b} : diff[2:0];
      q_bit    = ~borrow;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      prem_d  = prem_q;
      qsr_d   = qsr_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
`ifdef DIV0_DETECT_EN
      dz_d    = dz_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               dvd_d  = dividend;
               dvs_d  = divisor;
               prem_d = 3'd0;
               qsr_d  = 6'd0;
               cnt_d  = 3'd0;
               state_d = S_RUN;
`ifdef DIV0_DETECT_EN
               if (divisor == 3'd0) begin
                  // The result is known immediately, so the iterations are skipped.
                  quot_d  = 6'h3F;
                  rem_d   = 3'd0;
                  dz_d    = 1'b1;
                  state_d = S_DONE;
               end
`endif
            end
         end

         S_RUN: begin
            prem_d = prem_nxt;
            qsr_d  = {qsr_q[4:0], q_bit};
            dvd_d  = {dvd_q[4:0], 1'b0};
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd5) begin
               quot_d  = {qsr_q[4:0], q_bit};
               rem_d   = prem_nxt;
`ifdef DIV0_DETECT_EN
               dz_d    = 1'b0;
`endif
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         dvd_q   <= 6'd0;
         dvs_q   <= 3'd0;
         prem_q  <= 3'd0;
         qsr_q   <= 6'd0;
         cnt_q   <= 3'd0;
         quot_q  <= 6'd0;
         rem_q   <= 3'd0;
`ifdef DIV0_DETECT_EN
         dz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         prem_q  <= prem_d;
         qsr_q   <= qsr_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
`ifdef DIV0_DETECT_EN
         dz_q    <= dz_d;
`endif
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign quot = quot_q;
   assign rem  = rem_q;
`ifdef DIV0_DETECT_EN
   assign dz   = dz_q;
`else
   assign dz   = 1'b0;
`endif

endmodule
